// File: rtl/pc_gen_btb.sv
// Fetch-stage next-PC generator: stall handshake, EX/ID redirects and a
// direct-mapped BTB with 2-bit saturating direction counters.
module pc_gen_btb #(
   parameter int unsigned     XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_PC    = 'h8000_0000,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter int unsigned     INST_BYTES  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   output logic            pc_valid,
   output logic [XLEN-1:0] curr_pc,
   output logic            pred_taken,
   input  logic            ex_redirect,
   input  logic [XLEN-1:0] ex_target,
   input  logic            id_redirect,
   input  logic [XLEN-1:0] id_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
   localparam int unsigned TAGW = XLEN - IDX - 2;

   logic [XLEN-1:0] r_pc;
   logic            r_pc_valid;
   logic [XLEN-1:0] w_pc_next;

   logic [BTB_ENTRIES-1:0] w_ent_valid;
   logic [TAGW-1:0]        w_ent_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]        w_ent_target [BTB_ENTRIES];
   logic [1:0]             w_ent_ctr    [BTB_ENTRIES];

   logic [IDX-1:0]  w_lk_idx;
   logic [TAGW-1:0] w_lk_tag;
   logic [IDX-1:0]  w_up_idx;
   logic [TAGW-1:0] w_up_tag;
   logic            w_lk_hit;
   logic            w_pred_taken;
   logic            w_unused_upd_lsbs;

   assign w_lk_idx = r_pc[IDX+1:2];
   assign w_lk_tag = r_pc[XLEN-1:IDX+2];
   assign w_up_idx = upd_pc[IDX+1:2];
   assign w_up_tag = upd_pc[XLEN-1:IDX+2];

   // Instruction alignment bits never reach the BTB.
   assign w_unused_upd_lsbs = ^upd_pc[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
         logic            r_valid;
         logic [TAGW-1:0] r_tag;
         logic [XLEN-1:0] r_target;
         logic [1:0]      r_ctr;
         logic            w_sel;
         logic            w_hit;

         assign w_sel = upd_valid && (w_up_idx == IDX'(gi));
         assign w_hit = r_valid && (r_tag == w_up_tag);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_valid <= 1'b0;
            end else if (w_sel) begin
               if (w_hit) begin
                  if (upd_taken) begin
                     r_ctr    <= (r_ctr == 2'b11) ? 2'b11 : r_ctr + 2'd1;
                     r_target <= upd_target;
                  end else begin
                     r_ctr <= (r_ctr == 2'b00) ? 2'b00 : r_ctr - 2'd1;
                  end
               end else if (upd_taken) begin
                  // Allocate over whatever lived here, weakly taken.
                  r_valid  <= 1'b1;
                  r_tag    <= w_up_tag;
                  r_target <= upd_target;
                  r_ctr    <= 2'b10;
               end
            end
         end

         assign w_ent_valid[gi]  = r_valid;
         assign w_ent_tag[gi]    = r_tag;
         assign w_ent_target[gi] = r_target;
         assign w_ent_ctr[gi]    = r_ctr;
      end
   endgenerate

   // Lookup sees pre-update contents; a same-cycle write lands on the edge.
   assign w_lk_hit     = w_ent_valid[w_lk_idx] && (w_ent_tag[w_lk_idx] == w_lk_tag);
   assign w_pred_taken = r_pc_valid && w_lk_hit && w_ent_ctr[w_lk_idx][1];

   always_comb begin
      w_pc_next = r_pc;
      if (r_pc_valid) begin
         if (ex_redirect) begin
            w_pc_next = ex_target;
         end else if (id_redirect) begin
            w_pc_next = id_target;
         end else if (!fetch_ready) begin
            w_pc_next = r_pc;
         end else if (w_pred_taken) begin
            w_pc_next = w_ent_target[w_lk_idx];
         end else begin
            w_pc_next = r_pc + XLEN'(INST_BYTES);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_pc_valid <= 1'b0;
      end else begin
         r_pc       <= w_pc_next;
         r_pc_valid <= 1'b1;
      end
   end

   assign pc_valid   = r_pc_valid;
   assign curr_pc    = r_pc;
   assign pred_taken = w_pred_taken;

endmodule
